prio_arbiter8: RTL and testbench

- Eight-requester grant controller built around 8-to-3 priority encoding.
- Shares one downstream resource among eight requesters.
- Issues a registered one-hot grant plus an encoded grant index.
- Holds the grant until the owner releases it or a hold timeout fires.

---
 rtl/prio_arbiter8.sv | 126 ++++++++++++
 tb/tb_prio_arbiter8.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/prio_arbiter8.sv
`default_nettype none
// ============================================================================
//  Module      : prio_arbiter8
//  Description : Eight-requester grant controller. Encodes the request vector
//                to a single winner, issues a registered one-hot grant plus its
//                binary index, and holds it until the owner releases it (done
//                pulse or request drop) or MAX_HOLD cycles have elapsed.
//                Define PRIO_ARB_ROUND_ROBIN_EN to replace fixed priority
//                (req[7] highest) with a rotating-pointer round-robin search.
//  Revision    : 1.0 - initial release
// ============================================================================
module prio_arbiter8 #(
    parameter int MAX_HOLD = 16,
    parameter int CW       = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    input  logic       done,
    output logic [7:0] gnt,
    output logic [2:0] gnt_id,
    output logic       gnt_valid,
    output logic       timeout
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    localparam logic [CW-1:0] c_cnt_last = CW'(MAX_HOLD - 1);
    localparam logic [CW-1:0] c_cnt_sat  = CW'(MAX_HOLD);

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic [2:0]    w_winner;
    logic          w_rel_normal;
    logic          w_rel_limit;

`ifdef PRIO_ARB_ROUND_ROBIN_EN
    logic [2:0] r_ptr;
    logic [2:0] w_idx;
    logic       w_found;

    // Descending wrap-around search starting at the pointer; first hit wins.
    always_comb begin
        w_winner = 3'd0;
        w_found  = 1'b0;
        w_idx    = 3'd0;
        for (int i = 0; i < 8; i++) begin
            w_idx = r_ptr - 3'(i);
            if (!w_found && req[w_idx]) begin
                w_winner = w_idx;
                w_found  = 1'b1;
            end
        end
    end
`else
    // Fixed priority: scanning upward lets the highest set bit win.
    always_comb begin
        w_winner = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (req[i]) begin
                w_winner = 3'(i);
            end
        end
    end
`endif

    // Owner release (done or dropped request) takes precedence over the limit.
    always_comb begin
        w_rel_normal = done | ~req[gnt_id];
        w_rel_limit  = (r_cnt == c_cnt_last);
    end

    // Grant state machine with registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            gnt       <= 8'h00;
            gnt_id    <= 3'd0;
            gnt_valid <= 1'b0;
            timeout   <= 1'b0;
`ifdef PRIO_ARB_ROUND_ROBIN_EN
            r_ptr     <= 3'd7;
`endif
        end else begin
            timeout <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (|req) begin
                        r_state   <= ST_GRANT;
                        r_cnt     <= '0;
                        gnt       <= 8'h01 << w_winner;
                        gnt_id    <= w_winner;
                        gnt_valid <= 1'b1;
`ifdef PRIO_ARB_ROUND_ROBIN_EN
                        r_ptr     <= w_winner - 3'd1;
`endif
                    end
                end
                ST_GRANT: begin
                    if (w_rel_normal || w_rel_limit) begin
                        r_state   <= ST_GAP;
                        r_cnt     <= '0;
                        gnt       <= 8'h00;
                        gnt_valid <= 1'b0;
                        timeout   <= w_rel_limit & ~w_rel_normal;
                    end else if (r_cnt != c_cnt_sat) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_GAP: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_prio_arbiter8.sv
`default_nettype none
// ============================================================================
//  Module      : tb_prio_arbiter8
//  Description : Self-checking bench for prio_arbiter8. Directed scenarios and
//                random traffic are compared cycle by cycle against a
//                behavioural model of owner / hold-time / gap rules.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_prio_arbiter8;

    localparam int MAX_HOLD = 16;
    localparam int CW       = 5;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] req = 8'h00;
    logic       done = 1'b0;
    logic [7:0] gnt;
    logic [2:0] gnt_id;
    logic       gnt_valid;
    logic       timeout;

    int n_total = 0;
    int n_pass  = 0;

    // Reference model state
    int m_owner = -1;   // granted requester, -1 when none
    int m_held  = 0;    // cycles the current grant has already been visible
    bit m_gap   = 0;
    int m_id    = 0;
    bit m_to    = 0;
    int m_ptr   = 7;

    // Hold-length measurement for the timeout scenario
    bit measure = 0;
    int run_len = 0;

    prio_arbiter8 #(.MAX_HOLD(MAX_HOLD), .CW(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .done      (done),
        .gnt       (gnt),
        .gnt_id    (gnt_id),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    endtask

    function automatic int pick(input logic [7:0] r, input int ptr);
        int k;
        k = -1;
`ifdef PRIO_ARB_ROUND_ROBIN_EN
        for (int i = 0; i < 8; i++)
            if (k < 0 && r[(ptr - i + 8) % 8]) k = (ptr - i + 8) % 8;
`else
        for (int i = 7; i >= 0; i--)
            if (k < 0 && r[i]) k = i;
`endif
        return k;
    endfunction

    // Advance the model across one rising edge given the inputs seen there.
    task automatic model_step(input logic r, input logic [7:0] rq, input logic dn);
        bit normal;
        int k;
        m_to = 0;
        if (r) begin
            m_owner = -1; m_held = 0; m_gap = 0; m_id = 0; m_ptr = 7;
        end else if (m_owner >= 0) begin
            m_held++;
            normal = dn || !rq[m_owner];
            if (normal || m_held == MAX_HOLD) begin
                m_to    = !normal;
                m_owner = -1;
                m_gap   = 1;
            end
        end else if (m_gap) begin
            m_gap = 0;
        end else if (rq != 8'h00) begin
            k = pick(rq, m_ptr);
            m_owner = k;
            m_id    = k;
            m_held  = 0;
            m_ptr   = (k + 7) % 8;
        end
    endtask

    task automatic compare_outputs();
        logic [7:0] eg;
        eg = (m_owner >= 0) ? (8'h01 << m_owner) : 8'h00;
        check("gnt", 32'(gnt), 32'(eg));
        check("gnt_id", 32'(gnt_id), 32'(m_id));
        check("gnt_valid", 32'(gnt_valid), 32'(m_owner >= 0));
        check("timeout", 32'(timeout), 32'(m_to));
        if (measure) begin
            if (gnt == 8'h01) run_len++;
            else if (run_len > 0) begin
                check("hold_len", 32'(run_len), 32'(MAX_HOLD));
                check("timeout_at_fall", 32'(timeout), 32'd1);
                run_len = 0;
            end
        end
    endtask

    task automatic drive(input logic r, input logic [7:0] rq, input logic dn);
        @(negedge clk);
        rst = r; req = rq; done = dn;
        @(posedge clk);
        model_step(r, rq, dn);
        #1;
        compare_outputs();
    endtask

    initial begin
        logic [7:0] rq;
        // Reset, then done while idle must do nothing
        repeat (3) drive(1'b1, 8'h00, 1'b0);
        repeat (3) drive(1'b0, 8'h00, 1'b1);

        // Two steady requesters, done one cycle into each grant
        for (int c = 0; c < 30; c++)
            drive(1'b0, 8'b0010_0100, (m_owner >= 0 && m_held == 1));

        // All requesting, done two cycles into each grant
        drive(1'b1, 8'h00, 1'b0);
        for (int c = 0; c < 30; c++)
            drive(1'b0, 8'hFF, (m_owner >= 0 && m_held == 2));

        // Single requester never releasing: forced release after MAX_HOLD
        drive(1'b1, 8'h00, 1'b0);
        measure = 1;
        for (int c = 0; c < 45; c++) drive(1'b0, 8'h01, 1'b0);
        measure = 0;
        run_len = 0;

        // Owner 3 drops its request mid-grant while requester 6 waits
        drive(1'b1, 8'h00, 1'b0);
        for (int c = 0; c < 4; c++) drive(1'b0, 8'h08, 1'b0);
        for (int c = 0; c < 6; c++) drive(1'b0, 8'h40, 1'b0);

        // done lands on the limit cycle: normal release, no timeout
        drive(1'b1, 8'h00, 1'b0);
        for (int c = 0; c < 45; c++)
            drive(1'b0, 8'h01, (m_owner >= 0 && m_held == MAX_HOLD - 1));

        // Reset while requester 4 holds the grant
        drive(1'b1, 8'h00, 1'b0);
        for (int c = 0; c < 6; c++)
            drive((m_owner >= 0 && m_held == 2), 8'h10, 1'b0);

        // Random traffic
        rq = 8'h00;
        for (int c = 0; c < 2000; c++) begin
            if ($urandom_range(0, 3) == 0) rq = 8'($urandom) & 8'($urandom);
            drive(($urandom_range(0, 299) == 0), rq, ($urandom_range(0, 7) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
